nabp_angle_lut: RTL and testbench
=================================

Name: nabp_angle_lut

Overview:
- Per-projection-angle coefficient look-up for the NABP back-projector: merges mapper and shifter LUT functions in one registered block.
- Swap control supplies projection angle and current line count; block returns the scan mode, shifter accumulator increment, mapper accumulator increment and mapper per-line constant.
- One-cycle registered latency with valid qualifier; fixed-point output with FRAC_BITS fractional bits.

Parameters:
- ANGLE_WIDTH, 8: width of angle input; angle in whole degrees, legal 0..179.
- LINE_SIZE, 256: image line size; C = LINE_SIZE/2 (must be even).
- LINE_WIDTH, 8: width of line count, ceil(log2(LINE_SIZE)).
- FRAC_BITS, 12: fractional bits of all coefficient outputs; tables below defined for 12.
- CONST_WIDTH, 24: signed width of mapper constant output.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  angle/line_cnt valid this cycle
- angle  in  ANGLE_WIDTH  projection angle θ in degrees, unsigned
- line_cnt  in  LINE_WIDTH  current line index, unsigned
- out_valid  out  1  outputs valid (in_valid delayed 1 cycle)
- scan_mode  out  1  0 = x-scan, 1 = y-scan
- sh_accu_base  out  FRAC_BITS+1  unsigned shifter increment
- mp_accu_base  out  FRAC_BITS+2  signed mapper increment
- mp_accu_const_part  out  CONST_WIDTH  signed mapper per-line constant

Behaviour:
- Reset (reset_n=0 at clk edge): all outputs 0, out_valid 0. Reset mid-operation drops any pending result; no output the following cycle.
- Internal tables, integer constants:
  - S[k] = round(sin(k°)·2^FRAC_BITS), k = 0..90.
  - T[k] = round(tan(k°)·2^FRAC_BITS), k = 0..45.
  - Round half away from zero.
- Derived values:
  - sinθ = S[θ] for θ≤90, S[180−θ] otherwise.
  - cosθ = S[90−θ] for θ≤90, −S[θ−90] otherwise.
  - |tanθ| = T[θ] for θ≤45, T[180−θ] for θ≥135.
  - |cotθ| = T[90−θ] for 45≤θ≤90, T[θ−90] for 90<θ<135.
- scan_mode = 0 if θ<45 or θ≥135, else 1.
- x-mode outputs:
  - sh_accu_base = |tanθ|
  - mp_accu_base = cosθ
  - mp_accu_const_part = (line_cnt−C)·sinθ − C·cosθ + C·2^FRAC_BITS
- y-mode outputs:
  - sh_accu_base = |cotθ|
  - mp_accu_base = sinθ
  - mp_accu_const_part = (line_cnt−C)·cosθ − C·sinθ + C·2^FRAC_BITS
- Arithmetic is exact integer math on the table values, sign-extended to CONST_WIDTH; no overflow for the default parameters.
- Latency: inputs sampled at edge N with in_valid=1 → results and out_valid=1 after edge N (one cycle). in_valid=0 → out_valid=0 next cycle; data outputs hold their last value.
- Back-to-back valid inputs every cycle are supported; no back-pressure.
- Angle ≥180: scan_mode, sh_accu_base, mp_accu_base and mp_accu_const_part all 0; out_valid still follows in_valid.
- Boundaries:
  - θ=45 → y-mode, sh = 2^FRAC_BITS.
  - θ=135 → x-mode, sh = 2^FRAC_BITS.
  - θ=0 and θ=90 → sh = 0.

Optional Feature:
- Macro NABP_LUT_RANGE_CHECK_EN.
- Defined: extra output port angle_err (1 bit), registered with the other outputs.
  - angle_err = 1 when in_valid=1 and angle ≥180; reset value 0.
  - Simulation $display warning on each such input.
- Undefined: no angle_err port and no check; out-of-range angles still give zero outputs.

Test Plan:
- Reset: reset_n=0 for 2 cycles with in_valid=1 → out_valid=0, all outputs 0; first valid input after release → out_valid=1 exactly one cycle later.
- θ=30, line_cnt=0, valid → scan_mode=0, sh=2365, mp_base=3547, const=−191872.
- θ=90, line_cnt=0 → scan_mode=1, sh=0, mp_base=4096, const=0.
- θ=0, line_cnt=128 → scan_mode=0, sh=0, mp_base=4096, const=0.
- Boundaries:
  - θ=45 → scan_mode=1, sh=4096.
  - θ=135 → scan_mode=0, sh=4096, mp_base=−2896.
  - θ=44 → scan_mode=0.
- Streaming and range: θ = 0..179 on consecutive cycles with in_valid toggling → each valid result matches the formula model one cycle later. θ=200 → all data outputs 0, angle_err=1 when NABP_LUT_RANGE_CHECK_EN is defined.

Source files
------------

// File: rtl/nabp_angle_lut.sv
// nabp_angle_lut: per-angle coefficient look-up for the NABP back-projector.
// Returns scan mode, shifter/mapper accumulator increments and the mapper
// per-line constant, one registered cycle after a valid angle/line input.
// Optional build macro NABP_LUT_RANGE_CHECK_EN adds the angle_err output.
// The sine and tangent tables are built at elaboration time from an
// integer Taylor series, so they track FRAC_BITS automatically.
module nabp_angle_lut #(
  parameter int ANGLE_WIDTH = 8,
  parameter int LINE_SIZE   = 256,
  parameter int LINE_WIDTH  = 8,
  parameter int FRAC_BITS   = 12,
  parameter int CONST_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [ANGLE_WIDTH-1:0]        angle,
  input  logic [LINE_WIDTH-1:0]         line_cnt,
  output logic                          out_valid,
  output logic                          scan_mode,
  output logic [FRAC_BITS:0]            sh_accu_base,
  output logic signed [FRAC_BITS+1:0]   mp_accu_base,
  output logic signed [CONST_WIDTH-1:0] mp_accu_const_part
`ifdef NABP_LUT_RANGE_CHECK_EN
  ,
  output logic                          angle_err
`endif
);

  localparam int C = LINE_SIZE / 2;
  localparam longint PI_Q30 = 64'sd3373259426;  // pi * 2^30
  localparam logic signed [CONST_WIDTH-1:0] C_S      = CONST_WIDTH'(C);
  localparam logic signed [CONST_WIDTH-1:0] C_SCALED = CONST_WIDTH'(longint'(C) <<< FRAC_BITS);

  // sin(deg) in Q30 via Taylor series; deg is 0..90 so the argument stays
  // below pi/2 and every intermediate product fits in 64 bits.
  function automatic longint sin_fix(input int deg);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (longint'(deg) * PI_Q30) / 64'sd180;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // S[k]: sine scaled to FRAC_BITS, rounded half away from zero (value >= 0).
  function automatic int round_sin(input int deg);
    longint s;
    s = sin_fix(deg);
    return int'((s + (longint'(1) <<< (29 - FRAC_BITS))) >>> (30 - FRAC_BITS));
  endfunction

  // T[k]: tangent scaled to FRAC_BITS, rounded half away from zero; cos is
  // taken as sin(90-k) so tan(45) is exactly 1.0.
  function automatic int round_tan(input int deg);
    longint s;
    longint c;
    s = sin_fix(deg);
    c = sin_fix(90 - deg);
    return int'((2 * (s <<< FRAC_BITS) + c) / (2 * c));
  endfunction

  logic [FRAC_BITS:0] s_rom [0:90];
  logic [FRAC_BITS:0] t_rom [0:45];

  for (genvar k = 0; k <= 90; k++) begin : g_sin
    localparam int SV = round_sin(k);
    assign s_rom[k] = (FRAC_BITS + 1)'(SV);
  end

  for (genvar k = 0; k <= 45; k++) begin : g_tan
    localparam int TV = round_tan(k);
    assign t_rom[k] = (FRAC_BITS + 1)'(TV);
  end

  int                           th;
  logic                         in_range;
  logic                         y_mode;
  logic                         cos_neg;
  logic [6:0]                   sin_idx;
  logic [6:0]                   cos_idx;
  logic [5:0]                   sh_idx;
  logic signed [FRAC_BITS+1:0]  sin_v;
  logic signed [FRAC_BITS+1:0]  cos_v;
  logic signed [FRAC_BITS+1:0]  a_v;
  logic signed [FRAC_BITS+1:0]  b_v;
  logic signed [CONST_WIDTH-1:0] l_off;
  logic signed [CONST_WIDTH-1:0] a_ext;
  logic signed [CONST_WIDTH-1:0] b_ext;
  logic signed [CONST_WIDTH-1:0] cst_next;
  logic [FRAC_BITS:0]           sh_next;

  // Fold the angle into table indices; out-of-range angles index entry 0 (zero).
  always_comb begin
    th       = int'(angle);
    in_range = 1'b0;
    y_mode   = 1'b0;
    cos_neg  = 1'b0;
    sin_idx  = '0;
    cos_idx  = '0;
    sh_idx   = '0;
    if (th < 180) begin
      in_range = 1'b1;
      y_mode   = (th >= 45) && (th < 135);
      if (th <= 90) begin
        sin_idx = 7'(th);
        cos_idx = 7'(90 - th);
      end else begin
        sin_idx = 7'(180 - th);
        cos_idx = 7'(th - 90);
        cos_neg = 1'b1;
      end
      if (!y_mode) begin
        sh_idx = (th <= 45) ? 6'(th) : 6'(180 - th);
      end else begin
        sh_idx = (th <= 90) ? 6'(90 - th) : 6'(th - 90);
      end
    end
  end

  // Coefficient arithmetic: a multiplies the line offset, b is the increment.
  always_comb begin
    sin_v    = $signed({1'b0, s_rom[sin_idx]});
    cos_v    = $signed({1'b0, s_rom[cos_idx]});
    if (cos_neg) begin
      cos_v = -cos_v;
    end
    a_v      = y_mode ? cos_v : sin_v;
    b_v      = y_mode ? sin_v : cos_v;
    sh_next  = t_rom[sh_idx];
    l_off    = $signed(CONST_WIDTH'(line_cnt)) - C_S;
    a_ext    = CONST_WIDTH'(a_v);
    b_ext    = CONST_WIDTH'(b_v);
    cst_next = '0;
    if (in_range) begin
      cst_next = l_off * a_ext - C_S * b_ext + C_SCALED;
    end
  end

  logic                          vld_p1;
  logic                          scan_p1;
  logic [FRAC_BITS:0]            sh_p1;
  logic signed [FRAC_BITS+1:0]   mb_p1;
  logic signed [CONST_WIDTH-1:0] cst_p1;
  logic                          err_p1;

  // ---- stage p1: output register, data updates only on valid input ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      scan_p1 <= 1'b0;
      sh_p1   <= '0;
      mb_p1   <= '0;
      cst_p1  <= '0;
    end else begin
      vld_p1 <= in_valid;
      err_p1 <= in_valid && !in_range;
      if (in_valid) begin
        scan_p1 <= y_mode;
        sh_p1   <= sh_next;
        mb_p1   <= b_v;
        cst_p1  <= cst_next;
      end
    end
  end

  assign out_valid          = vld_p1;
  assign scan_mode          = scan_p1;
  assign sh_accu_base       = sh_p1;
  assign mp_accu_base       = mb_p1;
  assign mp_accu_const_part = cst_p1;

`ifdef NABP_LUT_RANGE_CHECK_EN
  assign angle_err = err_p1;
`ifndef SYNTHESIS
  // Warn about each out-of-range angle presented as valid.
  always @(posedge clk) begin
    if (reset_n && in_valid && !in_range) begin
      $display("nabp_angle_lut warning: angle %0d out of range", angle);
    end
  end
`endif
`else
  logic unused_err;
  assign unused_err = err_p1;
`endif

endmodule

// File: tb/tb_nabp_angle_lut.sv
// Bench for nabp_angle_lut: real-valued trigonometric reference model,
// per-cycle comparison plus literal expectations for key angles.
module tb_nabp_angle_lut;

  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic [7:0]         angle;
  logic [7:0]         line_cnt;
  logic               out_valid;
  logic               scan_mode;
  logic [12:0]        sh_accu_base;
  logic signed [13:0] mp_accu_base;
  logic signed [23:0] mp_accu_const_part;
`ifdef NABP_LUT_RANGE_CHECK_EN
  logic               angle_err;
`endif

  int checks = 0;
  int errors = 0;

  nabp_angle_lut dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .angle              (angle),
    .line_cnt           (line_cnt),
    .out_valid          (out_valid),
    .scan_mode          (scan_mode),
    .sh_accu_base       (sh_accu_base),
    .mp_accu_base       (mp_accu_base),
    .mp_accu_const_part (mp_accu_const_part)
`ifdef NABP_LUT_RANGE_CHECK_EN
    ,
    .angle_err          (angle_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($floor(x + 0.5));
    else          return -longint'($floor(-x + 0.5));
  endfunction

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  // Reference: outputs straight from trigonometry on the angle.
  task automatic model(input int th, input int l, output logic sm,
                       output longint sh, output longint mb, output longint cst);
    real    rad;
    longint s, c, a;
    sm = 1'b0; sh = 0; mb = 0; cst = 0;
    if (th < 180) begin
      rad = th * PI / 180.0;
      s   = rnd($sin(rad) * 4096.0);
      c   = rnd($cos(rad) * 4096.0);
      sm  = (th >= 45) && (th < 135);
      if (!sm) sh = rnd(absr($tan(rad)) * 4096.0);
      else     sh = rnd(absr($cos(rad) / $sin(rad)) * 4096.0);
      mb  = sm ? s : c;
      a   = sm ? c : s;
      cst = (longint'(l) - 128) * a - 128 * mb + 128 * 4096;
    end
  endtask

  logic   exp_vld = 1'b0;
  logic   exp_sm  = 1'b0;
  logic   exp_err = 1'b0;
  longint exp_sh  = 0;
  longint exp_mb  = 0;
  longint exp_cst = 0;

  // Model update at each edge from the stable inputs, then compare.
  always @(posedge clk) begin
    if (!reset_n) begin
      exp_vld = 1'b0; exp_err = 1'b0; exp_sm = 1'b0;
      exp_sh = 0; exp_mb = 0; exp_cst = 0;
    end else begin
      exp_vld = in_valid;
      exp_err = in_valid && (angle >= 8'd180);
      if (in_valid) model(int'(angle), int'(line_cnt), exp_sm, exp_sh, exp_mb, exp_cst);
    end
    #2;
    check("out_valid", longint'(out_valid), longint'(exp_vld));
    check("scan_mode", longint'(scan_mode), longint'(exp_sm));
    check("sh_accu_base", longint'(sh_accu_base), exp_sh);
    check("mp_accu_base", longint'(mp_accu_base), exp_mb);
    check("mp_const", longint'(mp_accu_const_part), exp_cst);
`ifdef NABP_LUT_RANGE_CHECK_EN
    check("angle_err", longint'(angle_err), longint'(exp_err));
`endif
  end

  task automatic drive(input int a, input int l, input logic v);
    @(negedge clk);
    angle    = 8'(a);
    line_cnt = 8'(l);
    in_valid = v;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b1;
    angle    = 8'd30;
    line_cnt = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_const", longint'(mp_accu_const_part), 0);
    check("rst_sh", longint'(sh_accu_base), 0);
    reset_n = 1'b1;

    angle = 8'd30; line_cnt = 8'd0; in_valid = 1'b1;
    after_edge();
    check("t30_valid", longint'(out_valid), 1);
    check("t30_scan", longint'(scan_mode), 0);
    check("t30_sh", longint'(sh_accu_base), 2365);
    check("t30_mb", longint'(mp_accu_base), 3547);
    check("t30_const", longint'(mp_accu_const_part), -191872);

    drive(90, 0, 1'b1); after_edge();
    check("t90_scan", longint'(scan_mode), 1);
    check("t90_sh", longint'(sh_accu_base), 0);
    check("t90_mb", longint'(mp_accu_base), 4096);
    check("t90_const", longint'(mp_accu_const_part), 0);

    drive(0, 128, 1'b1); after_edge();
    check("t0_scan", longint'(scan_mode), 0);
    check("t0_sh", longint'(sh_accu_base), 0);
    check("t0_mb", longint'(mp_accu_base), 4096);
    check("t0_const", longint'(mp_accu_const_part), 0);

    drive(45, 10, 1'b1); after_edge();
    check("t45_scan", longint'(scan_mode), 1);
    check("t45_sh", longint'(sh_accu_base), 4096);

    drive(135, 200, 1'b1); after_edge();
    check("t135_scan", longint'(scan_mode), 0);
    check("t135_sh", longint'(sh_accu_base), 4096);
    check("t135_mb", longint'(mp_accu_base), -2896);

    drive(44, 3, 1'b1); after_edge();
    check("t44_scan", longint'(scan_mode), 0);

    drive(44, 3, 1'b0); after_edge();
    check("idle_valid", longint'(out_valid), 0);
    check("idle_hold_sh", longint'(sh_accu_base), 3955);

    for (int th = 0; th < 180; th++) begin
      drive(th, int'($urandom_range(0, 255)), 1'b1);
      drive(th, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    drive(200, 77, 1'b1); after_edge();
    check("t200_valid", longint'(out_valid), 1);
    check("t200_scan", longint'(scan_mode), 0);
    check("t200_sh", longint'(sh_accu_base), 0);
    check("t200_mb", longint'(mp_accu_base), 0);
    check("t200_const", longint'(mp_accu_const_part), 0);
`ifdef NABP_LUT_RANGE_CHECK_EN
    check("t200_err", longint'(angle_err), 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n  = ($urandom_range(0, 99) != 0);
      angle    = 8'($urandom_range(0, 255));
      line_cnt = 8'($urandom_range(0, 255));
      in_valid = 1'($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
